// File: rtl/riscv_test_ctrl_if.sv
// Host-load, memory-write, CPU-observation and status bundle for the
// riscv_test_ctrl test sequencer. Signal names keep their direction prefix
// as seen from the sequencer, so "slave" is the sequencer side.
interface riscv_test_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
);
  logic              i_ld_valid;
  logic              o_ld_ready;
  logic              i_ld_sel;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [31:0]       i_ld_data;
  logic              i_start;
  logic              o_irom_we;
  logic [ADDR_W-1:0] o_irom_addr;
  logic [31:0]       o_irom_wdata;
  logic              o_dram_we;
  logic [ADDR_W-1:0] o_dram_addr;
  logic [31:0]       o_dram_wdata;
  logic              o_cpu_reset;
  logic [31:0]       i_cpu_inst;
  logic [31:0]       i_cpu_a0;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_result;
  logic              o_timeout;
  logic [CNT_W-1:0]  o_cycles;

  modport master (
    output i_ld_valid, i_ld_sel, i_ld_addr, i_ld_data, i_start,
           i_cpu_inst, i_cpu_a0,
    input  o_ld_ready, o_irom_we, o_irom_addr, o_irom_wdata,
           o_dram_we, o_dram_addr, o_dram_wdata, o_cpu_reset,
           o_busy, o_done, o_result, o_timeout, o_cycles
  );

  modport slave (
    input  i_ld_valid, i_ld_sel, i_ld_addr, i_ld_data, i_start,
           i_cpu_inst, i_cpu_a0,
    output o_ld_ready, o_irom_we, o_irom_addr, o_irom_wdata,
           o_dram_we, o_dram_addr, o_dram_wdata, o_cpu_reset,
           o_busy, o_done, o_result, o_timeout, o_cycles
  );
endinterface

// File: rtl/riscv_test_ctrl.sv
// Test sequencer for my_riscv_top: loads a test image into the inst ROM /
// data RAM write ports, holds the core in reset, runs it, detects the halt
// word at IF/ID and grades a0 against pass/fail magic values.
module riscv_test_ctrl #(
  parameter int          ADDR_W       = 10,
  parameter int          CNT_W        = 32,
  parameter int          MAX_CYCLES   = 10000,
  parameter int          RST_CYCLES   = 1,
  parameter int          DRAIN_CYCLES = 0,
  parameter logic [31:0] HALT_INST    = 32'hdead10cc,
  parameter logic [31:0] PASS_MAGIC   = 32'h00c0ffee,
  parameter logic [31:0] FAIL_MAGIC   = 32'hdeaddead
) (
  input logic              i_Clk,
  input logic              i_reset,
  riscv_test_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RST, RUN, CHECK, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  // Shared wait counter: RST hold length and CHECK drain length never overlap.
  logic [31:0]       phase_cnt;
  logic [ADDR_W-1:0] irom_addr;
  logic [ADDR_W-1:0] dram_addr;
  logic              accept;

  assign accept           = bus.i_ld_valid & bus.o_ld_ready;
  assign bus.o_irom_addr  = irom_addr;
  assign bus.o_dram_addr  = dram_addr;

  function automatic logic [1:0] grade_a0(input logic [31:0] a0);
    if (a0 == PASS_MAGIC)      grade_a0 = 2'b01;
    else if (a0 == FAIL_MAGIC) grade_a0 = 2'b10;
    else                       grade_a0 = 2'b11;
  endfunction

  // Load path and run-control FSM; every output is registered here.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      state            <= IDLE;
      cnt              <= '0;
      phase_cnt        <= '0;
      irom_addr        <= '0;
      dram_addr        <= '0;
      bus.o_irom_we    <= 1'b0;
      bus.o_irom_wdata <= '0;
      bus.o_dram_we    <= 1'b0;
      bus.o_dram_wdata <= '0;
      bus.o_ld_ready   <= 1'b1;
      bus.o_cpu_reset  <= 1'b1;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_result     <= 2'b00;
      bus.o_timeout    <= 1'b0;
      bus.o_cycles     <= '0;
    end else begin
      // A beat accepted this cycle becomes a one-cycle strobe next cycle,
      // independent of the FSM (a beat taken alongside i_start still lands).
      bus.o_irom_we <= accept & ~bus.i_ld_sel;
      bus.o_dram_we <= accept & bus.i_ld_sel;
      if (accept) begin
        if (bus.i_ld_sel) begin
          dram_addr        <= bus.i_ld_addr;
          bus.o_dram_wdata <= bus.i_ld_data;
        end else begin
          irom_addr        <= bus.i_ld_addr;
          bus.o_irom_wdata <= bus.i_ld_data;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (bus.i_start) begin
            state           <= RST;
            phase_cnt       <= '0;
            bus.o_ld_ready  <= 1'b0;
            bus.o_busy      <= 1'b1;
            bus.o_cpu_reset <= 1'b1;
            bus.o_done      <= 1'b0;
            bus.o_result    <= 2'b00;
            bus.o_timeout   <= 1'b0;
            bus.o_cycles    <= '0;
          end
        end
        RST: begin
          cnt <= '0;
          if (phase_cnt == 32'(RST_CYCLES - 1)) begin
            state           <= RUN;
            bus.o_cpu_reset <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        RUN: begin
          // Halt wins over timeout when both happen in the same cycle.
          if (bus.i_cpu_inst == HALT_INST) begin
            state        <= CHECK;
            phase_cnt    <= '0;
            bus.o_cycles <= cnt;
          end else if (cnt == CNT_W'(MAX_CYCLES)) begin
            state           <= DONE;
            bus.o_cycles    <= cnt;
            bus.o_timeout   <= 1'b1;
            bus.o_result    <= 2'b00;
            bus.o_done      <= 1'b1;
            bus.o_busy      <= 1'b0;
            bus.o_cpu_reset <= 1'b1;
            bus.o_ld_ready  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          // Core keeps running so in-flight writes to x10 retire before sampling.
          if (phase_cnt == 32'(DRAIN_CYCLES)) begin
            state           <= DONE;
            bus.o_result    <= grade_a0(bus.i_cpu_a0);
            bus.o_done      <= 1'b1;
            bus.o_busy      <= 1'b0;
            bus.o_cpu_reset <= 1'b1;
            bus.o_ld_ready  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Bench for riscv_test_ctrl: two instances with different timing parameters
// share host stimulus; each has its own core stub that shows the halt word at
// a chosen run cycle. Results are predicted from phase lengths and grading rules.
module tb_riscv_test_ctrl;
  localparam int AW      = 10;
  localparam int MAX_A   = 20;
  localparam int RST_A   = 1;
  localparam int DRAIN_A = 0;
  localparam int MAX_B   = 25;
  localparam int RST_B   = 3;
  localparam int DRAIN_B = 2;
  localparam logic [31:0] HALT  = 32'hdead10cc;
  localparam logic [31:0] PASSV = 32'h00c0ffee;
  localparam logic [31:0] BADV  = 32'hdeaddead;

  int p_max[2]   = '{MAX_A, MAX_B};
  int p_rst[2]   = '{RST_A, RST_B};
  int p_drain[2] = '{DRAIN_A, DRAIN_B};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ld_valid = 1'b0;
  logic          ld_sel   = 1'b0;
  logic [AW-1:0] ld_addr  = '0;
  logic [31:0]   ld_data  = '0;
  logic          start    = 1'b0;

  int          halt_at  = 1000;
  int          a0_delay = 0;
  logic [31:0] a0_early = '0;
  logic [31:0] a0_final = '0;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_test_ctrl_if #(.ADDR_W(AW), .CNT_W(32)) bus_a ();
  riscv_test_ctrl_if #(.ADDR_W(AW), .CNT_W(32)) bus_b ();

  assign bus_a.i_ld_valid = ld_valid;
  assign bus_a.i_ld_sel   = ld_sel;
  assign bus_a.i_ld_addr  = ld_addr;
  assign bus_a.i_ld_data  = ld_data;
  assign bus_a.i_start    = start;
  assign bus_b.i_ld_valid = ld_valid;
  assign bus_b.i_ld_sel   = ld_sel;
  assign bus_b.i_ld_addr  = ld_addr;
  assign bus_b.i_ld_data  = ld_data;
  assign bus_b.i_start    = start;

  // Core stubs: k counts cycles the core has been out of reset.
  int k[2];
  always @(posedge clk) begin
    if (bus_a.o_cpu_reset !== 1'b0) k[0] <= 0; else k[0] <= k[0] + 1;
    if (bus_b.o_cpu_reset !== 1'b0) k[1] <= 0; else k[1] <= k[1] + 1;
  end
  assign bus_a.i_cpu_inst = (bus_a.o_cpu_reset === 1'b0 && k[0] == halt_at) ? HALT : 32'h00000013;
  assign bus_b.i_cpu_inst = (bus_b.o_cpu_reset === 1'b0 && k[1] == halt_at) ? HALT : 32'h00000013;
  assign bus_a.i_cpu_a0   = (k[0] >= halt_at + a0_delay) ? a0_final : a0_early;
  assign bus_b.i_cpu_a0   = (k[1] >= halt_at + a0_delay) ? a0_final : a0_early;

  riscv_test_ctrl #(.ADDR_W(AW), .CNT_W(32), .MAX_CYCLES(MAX_A),
                    .RST_CYCLES(RST_A), .DRAIN_CYCLES(DRAIN_A))
    dut_a (.i_Clk(clk), .i_reset(rst), .bus(bus_a));
  riscv_test_ctrl #(.ADDR_W(AW), .CNT_W(32), .MAX_CYCLES(MAX_B),
                    .RST_CYCLES(RST_B), .DRAIN_CYCLES(DRAIN_B))
    dut_b (.i_Clk(clk), .i_reset(rst), .bus(bus_b));

  logic          s_done[2], s_busy[2], s_cr[2], s_ldr[2], s_iwe[2], s_dwe[2], s_to[2];
  logic [1:0]    s_res[2];
  logic [31:0]   s_cyc[2], s_idata[2], s_ddata[2];
  logic [AW-1:0] s_iaddr[2], s_daddr[2];
  assign s_done[0] = bus_a.o_done;        assign s_done[1] = bus_b.o_done;
  assign s_busy[0] = bus_a.o_busy;        assign s_busy[1] = bus_b.o_busy;
  assign s_cr[0]   = bus_a.o_cpu_reset;   assign s_cr[1]   = bus_b.o_cpu_reset;
  assign s_ldr[0]  = bus_a.o_ld_ready;    assign s_ldr[1]  = bus_b.o_ld_ready;
  assign s_iwe[0]  = bus_a.o_irom_we;     assign s_iwe[1]  = bus_b.o_irom_we;
  assign s_dwe[0]  = bus_a.o_dram_we;     assign s_dwe[1]  = bus_b.o_dram_we;
  assign s_to[0]   = bus_a.o_timeout;     assign s_to[1]   = bus_b.o_timeout;
  assign s_res[0]  = bus_a.o_result;      assign s_res[1]  = bus_b.o_result;
  assign s_cyc[0]  = bus_a.o_cycles;      assign s_cyc[1]  = bus_b.o_cycles;
  assign s_idata[0] = bus_a.o_irom_wdata; assign s_idata[1] = bus_b.o_irom_wdata;
  assign s_ddata[0] = bus_a.o_dram_wdata; assign s_ddata[1] = bus_b.o_dram_wdata;
  assign s_iaddr[0] = bus_a.o_irom_addr;  assign s_iaddr[1] = bus_b.o_irom_addr;
  assign s_daddr[0] = bus_a.o_dram_addr;  assign s_daddr[1] = bus_b.o_dram_addr;

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", (d == 0) ? "A" : "B", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] grade_ref(input logic [31:0] a0);
    if (a0 == PASSV) return 2'b01;
    if (a0 == BADV)  return 2'b10;
    return 2'b11;
  endfunction

  // Predicted outcome: done arrives after the RST hold, the run cycles up to
  // and including the halt cycle, and DRAIN+1 check cycles; a0 is read on the
  // core's run cycle h+1+DRAIN.
  function automatic void exp_run(input int d, input int h, input logic [31:0] early,
                                  input logic [31:0] fin, input int dly,
                                  output int t, output logic [1:0] res,
                                  output bit to, output int cyc);
    if (h <= p_max[d]) begin
      cyc = h;
      to  = 1'b0;
      t   = p_rst[d] + (h + 1) + (p_drain[d] + 1);
      res = grade_ref((dly <= p_drain[d] + 1) ? fin : early);
    end else begin
      cyc = p_max[d];
      to  = 1'b1;
      t   = p_rst[d] + (p_max[d] + 1);
      res = 2'b00;
    end
  endfunction

  task automatic chk_reset_vals(input int d);
    chk(d, "rst_cpu_reset", s_cr[d], 1);
    chk(d, "rst_ld_ready", s_ldr[d], 1);
    chk(d, "rst_irom_we", s_iwe[d], 0);
    chk(d, "rst_dram_we", s_dwe[d], 0);
    chk(d, "rst_irom_addr", s_iaddr[d], 0);
    chk(d, "rst_irom_wdata", s_idata[d], 0);
    chk(d, "rst_dram_addr", s_daddr[d], 0);
    chk(d, "rst_dram_wdata", s_ddata[d], 0);
    chk(d, "rst_busy", s_busy[d], 0);
    chk(d, "rst_done", s_done[d], 0);
    chk(d, "rst_result", s_res[d], 0);
    chk(d, "rst_timeout", s_to[d], 0);
    chk(d, "rst_cycles", s_cyc[d], 0);
  endtask

  task automatic do_run(input int h, input logic [31:0] early, input logic [31:0] fin,
                        input int dly, input bit beat_start, input bit hold_ld);
    int t_exp[2], cyc_exp[2], t_seen[2], first_low[2];
    logic [1:0] res_exp[2];
    bit to_exp[2], seen[2];
    halt_at = h; a0_early = early; a0_final = fin; a0_delay = dly;
    for (int d = 0; d < 2; d++) begin
      exp_run(d, h, early, fin, dly, t_exp[d], res_exp[d], to_exp[d], cyc_exp[d]);
      seen[d] = 1'b0; t_seen[d] = -1; first_low[d] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    if (beat_start || hold_ld) begin
      ld_valid = 1'b1; ld_sel = 1'b1;
      ld_addr  = beat_start ? 10'h009 : 10'h044;
      ld_data  = beat_start ? 32'h5a5a0009 : 32'h77770044;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (!hold_ld) ld_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "start_busy", s_busy[d], 1);
      chk(d, "start_done_clr", s_done[d], 0);
      chk(d, "start_cycles_clr", s_cyc[d], 0);
      chk(d, "start_result_clr", s_res[d], 0);
      chk(d, "start_timeout_clr", s_to[d], 0);
      chk(d, "start_cpu_reset", s_cr[d], 1);
      chk(d, "start_ld_ready", s_ldr[d], 0);
      if (beat_start || hold_ld) begin
        chk(d, "start_beat_we", s_dwe[d], 1);
        chk(d, "start_beat_addr", s_daddr[d], ld_addr);
        chk(d, "start_beat_data", s_ddata[d], ld_data);
      end
    end
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (hold_ld && n == 4) start = 1'b1;
      if (hold_ld && n == 5) start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (!seen[d]) begin
          if (first_low[d] < 0 && s_cr[d] == 1'b0) first_low[d] = n;
          if (s_done[d]) begin
            seen[d] = 1'b1; t_seen[d] = n;
          end else if (hold_ld) begin
            chk(d, "run_ld_ready", s_ldr[d], 0);
            chk(d, "run_no_we", s_dwe[d], 0);
          end
        end else if (hold_ld && n == t_seen[d] + 1) begin
          chk(d, "post_done_we", s_dwe[d], 1);
          chk(d, "post_done_addr", s_daddr[d], 10'h044);
        end
      end
      if (seen[0] && seen[1] && (!hold_ld || (n > t_seen[0] + 1 && n > t_seen[1] + 1))) break;
    end
    ld_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "done_reached", seen[d], 1);
      chk(d, "done_latency", t_seen[d], t_exp[d]);
      chk(d, "cpu_reset_hold", first_low[d], p_rst[d]);
      chk(d, "result", s_res[d], res_exp[d]);
      chk(d, "timeout", s_to[d], to_exp[d]);
      chk(d, "cycles", s_cyc[d], cyc_exp[d]);
      chk(d, "done_cpu_reset", s_cr[d], 1);
      chk(d, "done_busy", s_busy[d], 0);
      chk(d, "done_ld_ready", s_ldr[d], 1);
    end
  endtask

  typedef struct {
    bit v; bit sel; logic [AW-1:0] addr; logic [31:0] data;
    bit iwe; bit dwe; logic [AW-1:0] ia; logic [31:0] id; logic [AW-1:0] da; logic [31:0] dd;
  } ld_vec_t;
  ld_vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 10'h000, 32'h11111111, 1'b1, 1'b0, 10'h000, 32'h11111111, 10'h000, 32'h00000000};
    tbl[1] = '{1'b1, 1'b0, 10'h001, 32'h22222222, 1'b1, 1'b0, 10'h001, 32'h22222222, 10'h000, 32'h00000000};
    tbl[2] = '{1'b1, 1'b0, 10'h002, 32'h33333333, 1'b1, 1'b0, 10'h002, 32'h33333333, 10'h000, 32'h00000000};
    tbl[3] = '{1'b1, 1'b1, 10'h005, 32'h00c0ffee, 1'b0, 1'b1, 10'h002, 32'h33333333, 10'h005, 32'h00c0ffee};
    tbl[4] = '{1'b0, 1'b0, 10'h007, 32'hffffffff, 1'b0, 1'b0, 10'h002, 32'h33333333, 10'h005, 32'h00c0ffee};
    tbl[5] = '{1'b1, 1'b1, 10'h3ff, 32'hcafef00d, 1'b0, 1'b1, 10'h002, 32'h33333333, 10'h3ff, 32'hcafef00d};
    tbl[6] = '{1'b1, 1'b0, 10'h3ff, 32'h0badf00d, 1'b1, 1'b0, 10'h3ff, 32'h0badf00d, 10'h3ff, 32'hcafef00d};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk_reset_vals(d);
    rst = 1'b0;

    // Back-to-back load beats, strobe one cycle after each handshake.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ld_valid = tbl[i].v; ld_sel = tbl[i].sel; ld_addr = tbl[i].addr; ld_data = tbl[i].data;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk(d, $sformatf("ld%0d_irom_we", i), s_iwe[d], tbl[i].iwe);
        chk(d, $sformatf("ld%0d_dram_we", i), s_dwe[d], tbl[i].dwe);
        chk(d, $sformatf("ld%0d_irom_addr", i), s_iaddr[d], tbl[i].ia);
        chk(d, $sformatf("ld%0d_irom_wdata", i), s_idata[d], tbl[i].id);
        chk(d, $sformatf("ld%0d_dram_addr", i), s_daddr[d], tbl[i].da);
        chk(d, $sformatf("ld%0d_dram_wdata", i), s_ddata[d], tbl[i].dd);
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "idle_irom_we", s_iwe[d], 0);
      chk(d, "idle_dram_we", s_dwe[d], 0);
    end

    // Directed runs: pass, fail, unknown, drain-sensitive a0, timeout, halt at limit.
    do_run(5, 32'h0, PASSV, 0, 1'b0, 1'b0);
    do_run(5, 32'h0, BADV, 0, 1'b0, 1'b0);
    do_run(5, 32'h0, 32'h12345678, 0, 1'b0, 1'b0);
    do_run(5, 32'h0, PASSV, 2, 1'b0, 1'b0);
    do_run(1000, 32'h0, PASSV, 0, 1'b0, 1'b0);
    do_run(MAX_A, 32'h0, PASSV, 0, 1'b0, 1'b0);
    do_run(MAX_B, 32'h0, PASSV, 0, 1'b0, 1'b0);
    do_run(0, 32'h0, BADV, 1, 1'b1, 1'b0);
    do_run(10, 32'h0, PASSV, 0, 1'b0, 1'b1);

    // Reset while running: back to IDLE values at once.
    halt_at = 1000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int d = 0; d < 2; d++) chk_reset_vals(d);

    // Reset out of DONE with a beat in the reset cycle: status and strobe cleared.
    do_run(3, 32'h0, PASSV, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 10'h003; ld_data = 32'h99999999;
    @(posedge clk); #1;
    rst = 1'b0; ld_valid = 1'b0;
    for (int d = 0; d < 2; d++) chk_reset_vals(d);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk(d, "dropped_we", s_iwe[d], 0);
    do_run(4, 32'h0, PASSV, 0, 1'b0, 1'b0);

    // Randomised runs against the outcome model.
    for (int r = 0; r < 12; r++) begin
      int h, pick, dly;
      logic [31:0] fin, early;
      h     = $urandom_range(0, 30);
      pick  = $urandom_range(0, 2);
      dly   = $urandom_range(0, 3);
      early = $urandom;
      fin   = (pick == 0) ? PASSV : (pick == 1) ? BADV : $urandom;
      do_run(h, early, fin, dly, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
